// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package rr_stream_arbiter_pkg;

  localparam int MAX_IN = 32;
  localparam int PICK_W = 5;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // First set bit of valid scanning ptr, ptr+1, ... wrapping at n.
  // The loop runs downward so the lowest offset from ptr wins.
  function automatic pick_t rr_pick(input logic [MAX_IN-1:0] valid,
                                    input int ptr, input int n);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = MAX_IN-1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[PICK_W-1:0]]) begin
          p.found = 1'b1;
          p.idx   = idx[PICK_W-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_fifo2.sv
// Two-entry registered FIFO: head register drives the outputs, skid register
// absorbs one beat so the upstream ready depends only on registered state.
module stream_reg_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             space,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head, skid;
  logic             pop;

  assign pop      = out_valid && out_ready;
  assign space    = (count != 2'd2);
  assign out_data = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      head      <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (count)
        2'd0: begin
          if (in_valid) begin
            head      <= in_data;
            count     <= 2'd1;
            out_valid <= 1'b1;
          end
        end
        2'd1: begin
          if (in_valid && pop) begin
            head <= in_data;
          end else if (in_valid) begin
            skid  <= in_data;
            count <= 2'd2;
          end else if (pop) begin
            count     <= 2'd0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          // No push is possible here since space is low.
          if (pop) begin
            head  <= skid;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter: NUM_IN valid/ready streams share one registered
// output stream; a grant is held until the last beat of the packet is accepted.
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter  int NUM_IN     = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int SRC_W      = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_IN-1:0]            data_in_last,
  input  logic [NUM_IN-1:0]            data_in_valid,
  output logic [NUM_IN-1:0]            data_in_ready,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_out_last,
  output logic [SRC_W-1:0]             data_out_src,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic                         busy
);

  localparam int FW = DATA_WIDTH + 1 + SRC_W;

  arb_state_t         state;
  logic [SRC_W-1:0]   grant, rr_ptr;
  logic               space, accept;
  logic [1:0]         fifo_count;
  logic [MAX_IN-1:0]  valid_pad;
  pick_t              pick;
  logic [FW-1:0]      push_data, pop_data;

  assign valid_pad = MAX_IN'(data_in_valid);
  assign pick      = rr_pick(valid_pad, int'(rr_ptr), NUM_IN);
  assign accept    = (state == LOCKED) && data_in_valid[grant] && space;
  assign push_data = {data_in[int'(grant)*DATA_WIDTH +: DATA_WIDTH],
                      data_in_last[grant], grant};

  always_comb begin
    data_in_ready = '0;
    if (state == LOCKED) data_in_ready[grant] = space;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick.found) begin
            grant <= pick.idx[SRC_W-1:0];
            state <= LOCKED;
          end
        end
        default: begin
          // The lock is held through any valid gap until the last beat.
          if (accept && data_in_last[grant]) begin
            state  <= IDLE;
            rr_ptr <= (grant == SRC_W'(NUM_IN-1)) ? '0 : grant + 1'b1;
          end
        end
      endcase
    end
  end

  stream_reg_fifo2 #(.WIDTH(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (push_data),
    .in_valid  (accept),
    .space     (space),
    .out_data  (pop_data),
    .out_valid (data_out_valid),
    .out_ready (data_out_ready),
    .count     (fifo_count)
  );

  assign {data_out, data_out_last, data_out_src} = pop_data;
  assign busy = (state == LOCKED) || (fifo_count != 2'd0);

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: per-stream beat tables drive the
// inputs, accepted output beats are logged and compared to hand-built lists.
module tb_rr_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    data_in_last, data_in_valid, data_in_ready;
  logic [DW-1:0]   data_out;
  logic            data_out_last, data_out_valid, data_out_ready, busy;
  logic [SW-1:0]   data_out_src;

  rr_stream_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_last(data_in_last),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_last(data_out_last),
    .data_out_src(data_out_src), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] bd [N][16];
  logic          bl [N][16];
  int            nb [N];
  int            pos [N];
  logic          hold [N];

  logic [DW-1:0] od [$];
  logic          ol [$];
  logic [SW-1:0] os [$];
  int            oc [$];

  int   checks = 0, errors = 0, cyc = 0;
  int   rmode = 0, rphase = 0;
  logic mon_on = 1'b0, stall_prev = 1'b0, saw_full = 1'b0;
  logic [DW+SW:0] prev_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pos[i] < nb[i]) begin
        data_in[i*DW +: DW] = bd[i][pos[i][3:0]];
        data_in_last[i]     = bl[i][pos[i][3:0]];
        data_in_valid[i]    = !hold[i];
      end else begin
        data_in[i*DW +: DW] = '0;
        data_in_last[i]     = 1'b0;
        data_in_valid[i]    = 1'b0;
      end
    end
    data_out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (rphase % 3 == 0) : 1'b0;
  endtask

  // One clock: run invariants and log handshakes just before the edge.
  task automatic tick();
    logic [N-1:0] hs;
    logic         ohs;
    hs  = data_in_valid & data_in_ready;
    ohs = data_out_valid && data_out_ready;
    if (mon_on) begin
      chk("ready_onehot0", 64'($onehot0(data_in_ready)), 64'(1));
      if (dut.u_fifo.count == 2'd2) begin
        saw_full = 1'b1;
        chk("ready_when_full", 64'(data_in_ready), 64'(0));
      end
      if (stall_prev && !rst)
        chk("out_stable", 64'({data_out, data_out_last, data_out_src}), 64'(prev_out));
    end
    stall_prev = data_out_valid && !data_out_ready;
    prev_out   = {data_out, data_out_last, data_out_src};
    if (ohs && !rst) begin
      od.push_back(data_out); ol.push_back(data_out_last);
      os.push_back(data_out_src); oc.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++; rphase++;
    if (!rst) for (int i = 0; i < N; i++) if (hs[i]) pos[i]++;
    if (rst) stall_prev = 1'b0;
    drive();
  endtask

  task automatic clear_log();
    od.delete(); ol.delete(); os.delete(); oc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin nb[i] = 0; pos[i] = 0; hold[i] = 1'b0; end
    rmode = 0;
    drive();
    tick();
    rst = 1'b0;
    rphase = 0;
    drive();
    clear_log();
  endtask

  task automatic load(input int s, input int n, input logic [DW-1:0] base, input int last_at);
    for (int k = 0; k < n; k++) begin
      bd[s][k] = base + DW'(k);
      bl[s][k] = (k == last_at);
    end
    nb[s] = n; pos[s] = 0;
  endtask

  task automatic wait_beats(input string tag, input int want, input int bound);
    int n = 0;
    while (od.size() < want && n < bound) begin tick(); n++; end
    chk(tag, 64'(od.size() >= want), 64'(1));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    data_in = '0; data_in_last = '0; data_in_valid = '0; data_out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin nb[i] = 0; pos[i] = 0; hold[i] = 1'b0; end

    // Reset held with every stream valid
    for (int i = 0; i < N; i++) load(i, 8, DW'(32'hA0 + i), 0);
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) bd[i][k] = DW'(32'hA0 + i);
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) bl[i][k] = 1'b1;
    drive();
    for (int r = 0; r < 3; r++) begin
      tick();
      mon_on = 1'b1;
      chk("rst_ready", 64'(data_in_ready), 64'(0));
      chk("rst_valid", 64'(data_out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
    end
    chk("rst_data", 64'(data_out), 64'(0));
    rst = 1'b0;
    clear_log();
    tick();
    chk("first_lock_valid", 64'(data_out_valid), 64'(0));
    chk("first_lock_ready", 64'(data_in_ready), 64'(4'b0001));
    chk("first_lock_busy", 64'(busy), 64'(1));
    tick();
    chk("first_beat_valid", 64'(data_out_valid), 64'(1));
    chk("first_beat_data", 64'(data_out), 64'(32'hA0));
    chk("first_beat_src", 64'(data_out_src), 64'(0));

    // Round robin across single-beat packets
    wait_beats("rr_timeout", 5, 40);
    for (int k = 0; k < 5; k++) begin
      chk("rr_src", 64'(os[k]), 64'(k % 4));
      chk("rr_data", 64'(od[k]), 64'(32'hA0 + (k % 4)));
      if (k > 0) chk("rr_spacing", 64'(oc[k] - oc[k-1]), 64'(2));
    end

    // Packet lock: stream 2 owns the output for its 4 beats
    do_reset();
    load(2, 4, 32'hB0, 3);
    drive();
    tick();
    load(1, 1, 32'hC1, 0);
    drive();
    n = 0;
    while (od.size() < 5 && n < 30) begin
      if (pos[2] < 4) chk("lock_ready1", 64'(data_in_ready[1]), 64'(0));
      tick(); n++;
    end
    chk("lock_timeout", 64'(od.size() >= 5), 64'(1));
    for (int k = 0; k < 4; k++) begin
      chk("lock_src", 64'(os[k]), 64'(2));
      chk("lock_data", 64'(od[k]), 64'(32'hB0 + k));
    end
    chk("lock_next_src", 64'(os[4]), 64'(1));
    chk("lock_next_data", 64'(od[4]), 64'(32'hC1));

    // Backpressure with ready pattern 1,0,0
    do_reset();
    saw_full = 1'b0;
    load(0, 8, 32'hD0, 7);
    rmode = 1; rphase = 0;
    drive();
    wait_beats("bp_timeout", 8, 100);
    for (int k = 0; k < 8; k++) begin
      chk("bp_data", 64'(od[k]), 64'(32'hD0 + k));
      chk("bp_last", 64'(ol[k]), 64'(k == 7));
    end
    chk("bp_saw_full", 64'(saw_full), 64'(1));
    rmode = 0;

    // Granted stream drops valid mid-packet
    do_reset();
    load(3, 4, 32'hE0, 3);
    drive();
    tick();
    load(0, 1, 32'hF0, 0);
    drive();
    n = 0;
    while (pos[3] < 2 && n < 20) begin tick(); n++; end
    chk("gap_start_timeout", 64'(pos[3]), 64'(2));
    hold[3] = 1'b1;
    drive();
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("gap_busy", 64'(busy), 64'(1));
      chk("gap_ready0", 64'(data_in_ready[0]), 64'(0));
    end
    hold[3] = 1'b0;
    drive();
    wait_beats("gap_timeout", 5, 40);
    for (int k = 0; k < 4; k++) begin
      chk("gap_src", 64'(os[k]), 64'(3));
      chk("gap_data", 64'(od[k]), 64'(32'hE0 + k));
    end
    chk("gap_next_src", 64'(os[4]), 64'(0));

    // Reset mid-packet with two beats buffered, rr_ptr moved to 3 first
    do_reset();
    load(2, 1, 32'h20, 0);
    drive();
    wait_beats("mid_pre_timeout", 1, 20);
    rmode = 2;
    load(1, 6, 32'h10, 5);
    drive();
    n = 0;
    while (dut.u_fifo.count != 2'd2 && n < 20) begin tick(); n++; end
    chk("mid_fill", 64'(dut.u_fifo.count), 64'(2));
    chk("mid_fill_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    drive();
    tick();
    chk("mid_rst_valid", 64'(data_out_valid), 64'(0));
    chk("mid_rst_count", 64'(dut.u_fifo.count), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ready", 64'(data_in_ready), 64'(0));
    rst = 1'b0;
    rmode = 0;
    for (int i = 0; i < N; i++) load(i, 1, DW'(32'h50 + i), 0);
    clear_log();
    drive();
    wait_beats("mid_post_timeout", 2, 40);
    chk("mid_post_src0", 64'(os[0]), 64'(0));
    chk("mid_post_data0", 64'(od[0]), 64'(32'h50));
    chk("mid_post_src1", 64'(os[1]), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
